rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Write-side driver of the integer register file.
- Merges writebacks from two producers onto the single RF write port (rfwrite/waddr/wdata):
  - channel A: single-cycle ALU path.
  - channel B: multi-cycle unit path (load/mul), buffered in a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on registers with an outstanding channel-B write.

Parameters:
- FIFO_DEPTH, 2, channel-B buffer entries (power of 2, at least 2).
- MAX_STALL, 4, consecutive cycles a non-empty B FIFO may be blocked by A before B is forced through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  A accepted this cycle (combinational).
- a_addr  in  5  destination register.
- a_data  in  32  write data.
- b_valid  in  1  multi-cycle unit writeback request.
- b_ready  out  1  FIFO not full (combinational).
- b_addr  in  5  destination register.
- b_data  in  32  write data.
- iss_valid  in  1  an instruction targeting channel B issues this cycle.
- iss_addr  in  5  its destination register.
- chk_addr1  in  5  scoreboard lookup address 1.
- chk_addr2  in  5  scoreboard lookup address 2.
- busy1  out  1  pend[chk_addr1] (combinational read of registered vector).
- busy2  out  1  pend[chk_addr2].
- rfwrite  out  1  RF write enable (registered).
- waddr  out  5  RF write address (registered).
- wdata  out  32  RF write data (registered).

Behaviour:
- Reset, synchronous, with rst high at the edge:
  - rfwrite=0, waddr=0, wdata=0.
  - FIFO emptied; pend=0; stall_cnt=0.
  - Applies mid-operation: buffered B entries are discarded, nothing is written.
- B FIFO:
  - b_ready = !full. Push when b_valid && b_ready.
  - Pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty.
  - A pushed entry is visible at the head the next cycle; there is no same-cycle bypass.
- Arbitration, each cycle:
  - force = fifo_nonempty && stall_cnt == MAX_STALL.
  - a_ready = !force.
  - If a_valid && a_ready: select A.
  - Else if fifo_nonempty: pop the head and select B.
  - Else: nothing selected.
- Output register, latency 1:
  - The selected request loads waddr/wdata at the edge.
  - rfwrite = 1 if the selected addr != 0, else 0. Writes to x0 are consumed but suppressed.
  - With nothing selected, rfwrite=0 and waddr/wdata hold their previous values.
  - A request accepted in cycle N is visible in the RF from cycle N+2.
- Starvation counter stall_cnt:
  - Increments when fifo_nonempty and B is not popped.
  - Resets to 0 on any B pop or when the FIFO is empty.
  - Saturates at MAX_STALL.
  - When force is active, A is held off for exactly one cycle.
- Scoreboard pend[31:0]:
  - Set: iss_valid && iss_addr != 0 sets pend[iss_addr] at the edge.
  - Clear: a B pop clears pend[head addr].
  - Same addr set and cleared in one cycle: set wins (the newer instruction owns the register).
  - pend[0] is always 0.
  - A-channel writes never touch pend.
- Push and pop in the same cycle with the FIFO non-full: both occur and the count is unchanged.
- Ordering:
  - B entries are written in arrival order.
  - A may overtake buffered B entries. Issue logic must not send an A write to a pending register; this block does not check for it.

Decomposition:
- Package rf_wb_pkg:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - wb_req_t struct {addr, data}.
- Sub-module wb_fifo (parameter DEPTH; push/pop/full/empty/head) instantiated once for channel B.
- Arbitration, starvation counter, scoreboard and output register live in the top module.

Test Plan:
- Reset then idle: after rst is held for 2 cycles, rfwrite=0, waddr=0, wdata=0, busy1=busy2=0, b_ready=1, and rfwrite stays 0 with no requests.
- Basic A write: a_valid with addr=5, data=0xDEADBEEF in cycle N -> a_ready=1 in N; in cycle N+1, rfwrite=1, waddr=5, wdata=0xDEADBEEF; in N+2, rfwrite=0.
- x0 suppression: A write to addr=0, data=0x1 -> a_ready=1 and rfwrite stays 0. Issue iss_addr=0 -> busy stays 0 with chk_addr1=0.
- B with scoreboard:
  - iss_addr=7 -> busy1=1 (chk_addr1=7) from the next cycle.
  - b_valid with addr=7, data=0x1234 in cycle M -> pop in M+1 (no A traffic), then rfwrite=1, waddr=7, wdata=0x1234 in M+2.
  - busy1=0 from M+2.
- Full FIFO and starvation:
  - a_valid held high continuously; push B entries 3 (0xA) and 4 (0xB).
  - b_ready=0 while 2 entries are held.
  - After MAX_STALL=4 blocked cycles, a_ready=0 for one cycle and entry 3 is written.
  - 4 more blocked cycles later, entry 4 is written in order.
- Conflicts and mid-operation reset:
  - iss_addr=9 in the same cycle a B entry for addr=9 pops -> busy stays 1 afterwards.
  - Assert rst with 2 buffered B entries -> no rfwrite follows, FIFO empty, pend=0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths and request type for the register-file writeback path.
package rf_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer for multi-cycle writebacks; head is valid while not empty.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_req;
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and buffered multi-cycle writebacks onto the single RF write port
// and tracks registers with an outstanding multi-cycle write.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_STALL  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rfwrite,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata
);

  localparam int SW = $clog2(MAX_STALL + 1);

  logic                  fifo_full, fifo_empty, fifo_nonempty;
  logic                  b_push, b_pop, sel_a, force_b;
  wb_req_t               b_head, b_req;
  logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic                  rfwrite_q, rfwrite_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  assign b_req   = '{addr: b_addr, data: b_data};
  assign b_ready = !fifo_full;
  assign b_push  = b_valid && b_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (b_push),
    .push_req (b_req),
    .pop      (b_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (b_head)
  );

  assign fifo_nonempty = !fifo_empty;
  assign force_b       = fifo_nonempty && (stall_cnt_q == SW'(MAX_STALL));
  assign a_ready       = !force_b;
  assign sel_a         = a_valid && a_ready;
  assign b_pop         = !sel_a && fifo_nonempty;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!fifo_nonempty || b_pop)
      stall_cnt_d = '0;
    else if (stall_cnt_q != SW'(MAX_STALL))
      stall_cnt_d = stall_cnt_q + SW'(1);
  end

  // Clear before set: a new issue to the register being retired keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (b_pop)                      pend_d[b_head.addr] = 1'b0;
    if (iss_valid && iss_addr != '0) pend_d[iss_addr]   = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    rfwrite_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (sel_a) begin
      rfwrite_d = (a_addr != '0);
      waddr_d   = a_addr;
      wdata_d   = a_data;
    end else if (b_pop) begin
      rfwrite_d = (b_head.addr != '0);
      waddr_d   = b_head.addr;
      wdata_d   = b_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      pend_q      <= '0;
      rfwrite_q   <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      pend_q      <= pend_d;
      rfwrite_q   <= rfwrite_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy1   = pend_q[chk_addr1];
  assign busy2   = pend_q[chk_addr2];
  assign rfwrite = rfwrite_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with hand-computed expectations.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready, busy1, busy2, rfwrite;
  logic [4:0]  a_addr, b_addr, iss_addr, chk_addr1, chk_addr2, waddr;
  logic [31:0] a_data, b_data, wdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.FIFO_DEPTH(2), .MAX_STALL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .rfwrite   (rfwrite),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0;
    chk_addr1 = 0; chk_addr2 = 5;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_rfwrite", 32'(rfwrite), 0);
    check("rst_waddr",   32'(waddr),   0);
    check("rst_wdata",   wdata,        0);
    check("rst_busy1",   32'(busy1),   0);
    check("rst_busy2",   32'(busy2),   0);
    check("rst_b_ready", 32'(b_ready), 1);
    tick();
    check("idle_rfwrite", 32'(rfwrite), 0);

    // Basic A write
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #1 check("a_ready_basic", 32'(a_ready), 1);
    tick();
    a_valid = 0;
    check("a_rfwrite", 32'(rfwrite), 1);
    check("a_waddr",   32'(waddr),   5);
    check("a_wdata",   wdata,        32'hDEADBEEF);
    tick();
    check("a_rfwrite_off", 32'(rfwrite), 0);
    check("a_waddr_hold",  32'(waddr),   5);

    // x0 suppression on both write and issue
    a_valid = 1; a_addr = 0; a_data = 32'h1;
    iss_valid = 1; iss_addr = 0;
    #1 check("x0_a_ready", 32'(a_ready), 1);
    tick();
    a_valid = 0; iss_valid = 0; chk_addr1 = 0;
    check("x0_rfwrite", 32'(rfwrite), 0);
    check("x0_waddr",   32'(waddr),   0);
    check("x0_wdata",   wdata,        32'h1);
    check("x0_busy1",   32'(busy1),   0);

    // B write clears the scoreboard entry set by issue
    iss_valid = 1; iss_addr = 7; chk_addr1 = 7;
    #1 check("iss7_busy_before", 32'(busy1), 0);
    tick();
    iss_valid = 0;
    check("iss7_busy", 32'(busy1), 1);
    b_valid = 1; b_addr = 7; b_data = 32'h1234;   // cycle M
    #1 check("b7_ready", 32'(b_ready), 1);
    tick();                                      // M+1: pop
    b_valid = 0;
    check("b7_busy_m1",    32'(busy1),   1);
    check("b7_rfwrite_m1", 32'(rfwrite), 0);
    tick();                                      // M+2
    check("b7_rfwrite", 32'(rfwrite), 1);
    check("b7_waddr",   32'(waddr),   7);
    check("b7_wdata",   wdata,        32'h1234);
    check("b7_busy_m2", 32'(busy1),   0);

    // Full FIFO and starvation with A held high
    a_valid = 1; a_addr = 1; a_data = 32'h55;
    b_valid = 1; b_addr = 3; b_data = 32'hA;     // cycle P
    #1 check("st_b_ready_p0", 32'(b_ready), 1);
    check("st_a_ready_p0", 32'(a_ready), 1);
    tick();                                      // P+1
    b_addr = 4; b_data = 32'hB;
    #1 check("st_b_ready_p1", 32'(b_ready), 1);
    check("st_a_ready_p1", 32'(a_ready), 1);
    for (int k = 2; k <= 11; k++) begin
      tick();
      b_valid = 0;
      #1;
      check($sformatf("st_a_ready_p%0d", k), 32'(a_ready), (k == 5 || k == 10) ? 0 : 1);
      check($sformatf("st_b_ready_p%0d", k), 32'(b_ready), (k >= 2 && k <= 5) ? 0 : 1);
      check($sformatf("st_rfwrite_p%0d", k), 32'(rfwrite), 1);
      check($sformatf("st_waddr_p%0d", k), 32'(waddr),
            (k == 6) ? 3 : (k == 11) ? 4 : 1);
      check($sformatf("st_wdata_p%0d", k), wdata,
            (k == 6) ? 32'hA : (k == 11) ? 32'hB : 32'h55);
    end
    a_valid = 0;

    // Issue and pop of the same register in one cycle: set wins
    chk_addr2 = 9;
    iss_valid = 1; iss_addr = 9;
    b_valid = 1; b_addr = 9; b_data = 32'h99;    // cycle Q
    tick();                                      // Q+1: pop of 9 plus a new issue to 9
    b_valid = 0;
    #1 check("cf_busy_q1", 32'(busy2), 1);
    tick();
    iss_valid = 0;
    check("cf_busy_q2",  32'(busy2),   1);
    check("cf_rfwrite",  32'(rfwrite), 1);
    check("cf_waddr",    32'(waddr),   9);
    check("cf_wdata",    wdata,        32'h99);
    tick();
    check("cf_busy_q3",  32'(busy2),   1);

    // Reset with two buffered B entries
    chk_addr1 = 10;
    a_valid = 1; a_addr = 2; a_data = 32'h2;
    iss_valid = 1; iss_addr = 10;
    b_valid = 1; b_addr = 11; b_data = 32'h11;   // cycle R
    tick();
    iss_valid = 0;
    b_addr = 12; b_data = 32'h12;
    tick();
    a_valid = 0; b_valid = 0;
    rst = 1'b1;
    #1 check("mr_b_ready_full", 32'(b_ready), 0);
    check("mr_busy1_set", 32'(busy1), 1);
    tick();
    rst = 1'b0;
    #1 check("mr_rfwrite0", 32'(rfwrite), 0);
    check("mr_b_ready",  32'(b_ready), 1);
    check("mr_busy1",    32'(busy1),   0);
    check("mr_busy2",    32'(busy2),   0);
    check("mr_waddr",    32'(waddr),   0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("mr_rfwrite%0d", k), 32'(rfwrite), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
